// File: rtl/i2c_reg_master.sv
// Single-transaction I2C register master: START, {chip,rw}, reg, data (write or read), STOP.
// Each bus bit is four quarter-phases of CLK_DIV system clocks; SCL is push-pull, SDA open-drain.
module i2c_reg_master #(
   parameter int CLK_DIV   = 4,
   parameter bit ACK_CHECK = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_chip_id,
   input  logic [7:0] cmd_reg_addr,
   input  logic       cmd_wr1rd0,
   input  logic [7:0] cmd_wr_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_rd_data,
   output logic       rsp_nack,
   output logic       busy,
   output logic       scl_o,
   output logic       sda_oe,
   input  logic       sda_i
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ACK_A, S_REG, S_ACK_R,
      S_WDATA, S_ACK_W, S_RDATA, S_MACK, S_STOP, S_DONE
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state, state_nx;
   logic [7:0] div_cnt;
   logic [1:0] qtr;
   logic [2:0] bit_cnt;
   logic [1:0] pad_cnt;
   logic [6:0] chip_q;
   logic [7:0] reg_q, wdat_q, rx_sh, tx_byte;
   logic       wr_q, nack_q, abort_q;
   logic       accept, tick, slot_end, sample, tx_bit;

   assign accept   = cmd_valid && (state == S_IDLE);
   assign tick     = (div_cnt == DIV_LAST);
   assign slot_end = tick && (qtr == 2'd3);
   // SDA is sampled on the Q2->Q3 edge, i.e. in the middle of SCL high
   assign sample   = tick && (qtr == 2'd2);

   always_comb begin
      tx_byte = wdat_q;
      if (state == S_ADDR)     tx_byte = {chip_q, wr_q};
      else if (state == S_REG) tx_byte = reg_q;
      tx_bit = tx_byte[3'd7 - bit_cnt];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nx = S_START;
         S_START: if (slot_end) state_nx = S_ADDR;
         S_ADDR:  if (slot_end && bit_cnt == 3'd7) state_nx = S_ACK_A;
         S_ACK_A: if (slot_end) state_nx = (ACK_CHECK && nack_q) ? S_STOP : S_REG;
         S_REG:   if (slot_end && bit_cnt == 3'd7) state_nx = S_ACK_R;
         S_ACK_R: if (slot_end) state_nx = wr_q ? S_WDATA : S_RDATA;
         S_WDATA: if (slot_end && bit_cnt == 3'd7) state_nx = S_ACK_W;
         S_ACK_W: if (slot_end) state_nx = S_STOP;
         S_RDATA: if (slot_end && bit_cnt == 3'd7) state_nx = S_MACK;
         S_MACK:  if (slot_end) state_nx = S_STOP;
         // aborted frames hold the bus idle for three extra slots so they last a fixed 14 slots
         S_STOP:  if (slot_end && (!abort_q || pad_cnt == 2'd3)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         qtr         <= '0;
         bit_cnt     <= '0;
         pad_cnt     <= '0;
         chip_q      <= '0;
         reg_q       <= '0;
         wdat_q      <= '0;
         wr_q        <= 1'b0;
         rx_sh       <= '0;
         nack_q      <= 1'b0;
         abort_q     <= 1'b0;
         rsp_rd_data <= '0;
         rsp_nack    <= 1'b0;
      end else begin
         if (accept) begin
            chip_q  <= cmd_chip_id;
            reg_q   <= cmd_reg_addr;
            wdat_q  <= cmd_wr_data;
            wr_q    <= cmd_wr1rd0;
            div_cnt <= '0;
            qtr     <= '0;
            bit_cnt <= '0;
            pad_cnt <= '0;
            rx_sh   <= '0;
            nack_q  <= 1'b0;
            abort_q <= 1'b0;
         end else if (state != S_IDLE && state != S_DONE) begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            if (tick) qtr <= qtr + 2'd1;
            if (sample) begin
               if (state inside {S_ACK_A, S_ACK_R, S_ACK_W}) nack_q <= nack_q | sda_i;
               if (state == S_RDATA) rx_sh <= {rx_sh[6:0], sda_i};
            end
            if (slot_end) begin
               if (state inside {S_ADDR, S_REG, S_WDATA, S_RDATA}) bit_cnt <= bit_cnt + 3'd1;
               if (state == S_ACK_A && ACK_CHECK && nack_q) abort_q <= 1'b1;
               if (state == S_STOP && abort_q) pad_cnt <= pad_cnt + 2'd1;
            end
         end
         if (state == S_STOP && state_nx == S_DONE) begin
            rsp_rd_data <= (wr_q || abort_q) ? 8'h00 : rx_sh;
            rsp_nack    <= nack_q;
         end
      end
   end

   always_comb begin
      scl_o     = 1'b1;
      sda_oe    = 1'b0;
      cmd_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      rsp_valid = (state == S_DONE);
      case (state)
         S_START: begin
            scl_o  = (qtr != 2'd3);
            sda_oe = qtr[1];
         end
         S_ADDR, S_REG, S_WDATA: begin
            scl_o  = qtr[1];
            sda_oe = ~tx_bit;
         end
         S_ACK_A, S_ACK_R, S_ACK_W, S_RDATA, S_MACK: scl_o = qtr[1];
         S_STOP: if (pad_cnt == 2'd0) begin
            scl_o  = (qtr != 2'd0);
            sda_oe = ~qtr[1];
         end
         default: ;
      endcase
   end

endmodule

// File: doc/i2c_reg_master.md
Name: i2c_reg_master

Overview:
- System-clock I2C master that sequences one register transaction on the team's I2C register bus.
- A host-side command (chip id, register address, direction, write data) becomes: START, address byte, register byte, data byte (written or read), STOP.
- Read data and an ACK status are returned to the host.
- Sits between the local host/sequencer and the SCL/SDA pads feeding the on-board I2C register slaves.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-bit (legal range 1..255); one bit = 4*CLK_DIV cycles.
- ACK_CHECK, 0, 1 = abort on NACK after the address byte; 0 = ignore sampled ACK bits (status still reported).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high only in IDLE; command accepted on clk edge where cmd_valid && cmd_ready.
- cmd_chip_id  in  7  target slave address.
- cmd_reg_addr  in  8  register address.
- cmd_wr1rd0  in  1  1 = register write, 0 = register read (bus encoding, sent as address-byte LSB).
- cmd_wr_data  in  8  write data.
- rsp_valid  out  1  one-cycle pulse at transaction end.
- rsp_rd_data  out  8  read data, valid with rsp_valid (0 for writes and aborts).
- rsp_nack  out  1  valid with rsp_valid: any sampled ACK slot was high.
- busy  out  1  high from acceptance until rsp_valid cycle inclusive.
- scl_o  out  1  SCL, push-pull (no clock stretching supported).
- sda_oe  out  1  1 = pull SDA low, 0 = release (open-drain pad).
- sda_i  in  1  SDA pad input, sampled directly (board-level sync not required; sampled mid-high phase).

Behaviour:
- Reset (async): state IDLE, scl_o=1, sda_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rd_data=0, rsp_nack=0, all counters 0.
- Reset mid-transaction: bus released immediately; no STOP is generated; no rsp_valid.
- On accept, latch all cmd_* fields; later cmd_* changes have no effect.
- Quarter-phase counter advances every CLK_DIV cycles. Per data bit, Q0: SCL low, SDA updated; Q1: SCL low; Q2: SCL high; Q3: SCL high, sda_i sampled at Q3 entry.
- Frames are MSB first. Bit slots: addr byte = {chip_id, wr1rd0} + ACK slot; register byte + ACK slot; data byte + ACK slot.
- States: IDLE, START, ADDR, ACK_A, REG, ACK_R, then WDATA, ACK_W (write) or RDATA, MACK (read), then STOP, DONE.
- START (4 quarters): Q0-Q1 SCL=1, SDA released; Q2 sda_oe=1 with SCL high; Q3 SCL=0.
- ACK slots (ACK_A/ACK_R/ACK_W): sda_oe=0; sampled bit ORed into a sticky nack flag.
- If ACK_CHECK=1 and the ACK_A sample is 1: go to STOP, skip remaining bytes, rsp_nack=1, rsp_rd_data=0.
- RDATA: sda_oe=0 for 8 bits; shift in sda_i at each sample point.
- MACK: master releases SDA (NACK, last byte); not counted in nack.
- STOP (4 quarters): Q0 SCL=0 and sda_oe=1; Q1 SCL=1; Q2 sda_oe=0 (SDA rises while SCL high); Q3 idle-high.
- DONE: one cycle; rsp_valid=1; return to IDLE next cycle.
- Latency: full transaction = 29 slots (START + 27 bits + STOP) = 116*CLK_DIV cycles from accept edge to rsp_valid cycle. Aborted transaction = 14*4*CLK_DIV cycles.
- Back-to-back commands: a command held valid during the DONE cycle is not accepted. Earliest acceptance is the cycle after rsp_valid, giving a minimum of one bus-free quarter beyond the STOP Q3.
- rsp_* outputs hold their values until the next DONE.
- No backpressure on rsp.

Test Plan:
- CLK_DIV=2, write chip 0x2A reg 0x10 data 0xC3, slave model ACKs -> SDA bytes 0x55, 0x10, 0xC3; rsp_valid exactly 232 cycles after accept; rsp_nack=0; rsp_rd_data=0.
- Read chip 0x2A reg 0x05, slave returns 0x9E -> address byte 0x54; rsp_rd_data=0x9E; master releases SDA in MACK slot.
- ACK_CHECK=1, no slave responding (SDA pulled up) -> STOP after ACK_A; rsp_nack=1 at 112 cycles (CLK_DIV=2); no register byte on bus.
- ACK_CHECK=0, no slave -> full 232-cycle frame; rsp_nack=1.
- cmd_valid asserted during busy, and cmd_* toggled mid-frame -> ignored; bus bytes match the latched command; cmd_ready=0 throughout.
- rst_n pulsed low during REG byte -> same cycle: scl_o=1, sda_oe=0, busy=0; no rsp_valid; next command runs normally.
